// File: rtl/sram_param_init.sv
// Simple-dual-port SRAM with a zero-fill init engine, selectable collision policy and range checking.
// Latency: READ_LAT edges from an accepted read to Rout/Rvalid; writes land at the sampling edge.
// Backpressure: none; accesses while busy or out of range are dropped/zeroed and flagged on err.
module sram_param_init #(
    parameter int DATA_W      = 6,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter int READ_LAT    = 1,
    parameter int WRITE_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [ADDR_W-1:0] Waddr,
    input  logic [DATA_W-1:0] Data,
    input  logic              rd,
    input  logic [ADDR_W-1:0] Raddr,
    output logic [DATA_W-1:0] Rout,
    output logic              Rvalid,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_dat;

    assign run         = (state == RUN);
    assign wr_in_range = ({1'b0, Waddr} < DEPTH_C);
    assign rd_in_range = ({1'b0, Raddr} < DEPTH_C);
    assign wr_ok       = wr & run & wr_in_range;
    assign rd_acc      = rd & run;

    // Out-of-range reads still complete, but return zero rather than an aliased word.
    always_comb begin
        rd_dat = '0;
        if (rd_in_range) begin
            if ((WRITE_FIRST != 0) && wr_ok && (Waddr == Raddr)) begin
                rd_dat = Data;
            end else begin
                rd_dat = mem[Raddr];
            end
        end
    end

    // Array has no reset; the fill engine owns the write port while in INIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem[ptr] <= '0;
            end else if (wr_ok) begin
                mem[Waddr] <= Data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
            busy  <= 1'b1;
            err   <= 1'b0;
        end else begin
            err <= run ? ((wr & ~wr_in_range) | (rd & ~rd_in_range)) : (wr | rd);
            case (state)
                INIT: begin
                    if (clr) begin
                        ptr <= '0;
                    end else if (ptr == LAST) begin
                        state <= RUN;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= INIT;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Reads already in flight are not flushed by clr; only rst empties the pipeline.
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              s_vld;
            logic [DATA_W-1:0] s_dat;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_vld  <= 1'b0;
                    s_dat  <= '0;
                    Rvalid <= 1'b0;
                    Rout   <= '0;
                end else begin
                    s_vld  <= rd_acc;
                    Rvalid <= s_vld;
                    if (rd_acc) begin
                        s_dat <= rd_dat;
                    end
                    if (s_vld) begin
                        Rout <= s_dat;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    Rvalid <= 1'b0;
                    Rout   <= '0;
                end else begin
                    Rvalid <= rd_acc;
                    if (rd_acc) begin
                        Rout <= rd_dat;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_param_init.sv
// Scoreboard bench: two configurations driven in lockstep (A: 32 deep, latency 1, read-first;
// B: 24 deep, latency 2, write-first), each with its own read-data and err expectation queues.
module tb_sram_param_init;

    localparam int DW  = 6;
    localparam int AW  = 5;
    localparam int D_A = 32;
    localparam int L_A = 1;
    localparam int D_B = 24;
    localparam int L_B = 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          clr   = 1'b0;
    logic          wr    = 1'b0;
    logic          rd    = 1'b0;
    logic [AW-1:0] Waddr = '0;
    logic [AW-1:0] Raddr = '0;
    logic [DW-1:0] Data  = '0;

    logic [DW-1:0] a_rout, b_rout;
    logic          a_rvalid, b_rvalid, a_busy, b_busy, a_err, b_err;

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] qa_d[$];
    logic [DW-1:0] qb_d[$];
    int            qa_t[$];
    int            qb_t[$];
    int            ea_t[$];
    int            eb_t[$];

    int            mon_ta, mon_tb;
    logic [DW-1:0] mon_da, mon_db;

    sram_param_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D_A), .READ_LAT(L_A), .WRITE_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .Waddr(Waddr), .Data(Data),
        .rd(rd), .Raddr(Raddr), .Rout(a_rout), .Rvalid(a_rvalid), .busy(a_busy), .err(a_err)
    );

    sram_param_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D_B), .READ_LAT(L_B), .WRITE_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .Waddr(Waddr), .Data(Data),
        .rd(rd), .Raddr(Raddr), .Rout(b_rout), .Rvalid(b_rvalid), .busy(b_busy), .err(b_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_rd(input logic [DW-1:0] va, input logic [DW-1:0] vb);
        qa_d.push_back(va); qa_t.push_back(cyc + L_A);
        qb_d.push_back(vb); qb_t.push_back(cyc + L_B);
    endtask

    task automatic exp_err(input bit ea, input bit eb);
        if (ea) ea_t.push_back(cyc + 1);
        if (eb) eb_t.push_back(cyc + 1);
    endtask

    task automatic step(input logic r, input logic [AW-1:0] ra, input logic w,
                        input logic [AW-1:0] wa, input logic [DW-1:0] d, input logic c);
        rd = r; Raddr = ra; wr = w; Waddr = wa; Data = d; clr = c;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0);
    endtask

    task automatic do_rd(input logic [AW-1:0] a, input logic [DW-1:0] va, input logic [DW-1:0] vb,
                         input bit ea, input bit eb);
        exp_rd(va, vb);
        exp_err(ea, eb);
        step(1, a, 0, '0, '0, 0);
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ea, input bit eb);
        exp_err(ea, eb);
        step(0, '0, 1, a, d, 0);
    endtask

    // Counts edges until each busy falls; optionally pokes a write then a read into the busy window.
    task automatic measure_busy(input bit inject, output int la, output int lb);
        la = -1;
        lb = -1;
        for (int k = 1; k <= 40; k++) begin
            if (la >= 0 && lb >= 0) break;
            if (inject && k == 5) begin
                exp_err(1, 1);
                step(0, '0, 1, 5'd0, 6'h3f, 0);
            end else if (inject && k == 6) begin
                exp_err(1, 1);
                step(1, 5'd0, 0, '0, '0, 0);
            end else begin
                step(0, '0, 0, '0, '0, 0);
            end
            if (la < 0 && !a_busy) la = k;
            if (lb < 0 && !b_busy) lb = k;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rout_a"},   a_rout,   '0);
        check({tag, "_rvalid_a"}, a_rvalid, 0);
        check({tag, "_err_a"},    a_err,    0);
        check({tag, "_busy_a"},   a_busy,   1);
        check({tag, "_rout_b"},   b_rout,   '0);
        check({tag, "_rvalid_b"}, b_rvalid, 0);
        check({tag, "_err_b"},    b_err,    0);
        check({tag, "_busy_b"},   b_busy,   1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (qa_t.size() > 0 && qa_t[0] < cyc) begin
                n_vec++; n_bad++;
                $display("FAIL a_rd_missing: no Rvalid by cycle %0d, want Rout %0h", cyc, qa_d[0]);
                mon_ta = qa_t.pop_front(); mon_da = qa_d.pop_front();
            end
            if (a_rvalid) begin
                if (qa_t.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL a_rd_unexpected: got Rvalid with Rout %0h at cycle %0d, want none", a_rout, cyc);
                end else begin
                    mon_ta = qa_t.pop_front(); mon_da = qa_d.pop_front();
                    check("a_rd_data", a_rout, mon_da);
                    check("a_rd_cycle", cyc, mon_ta);
                end
            end
            if (ea_t.size() > 0 && ea_t[0] < cyc) begin
                n_vec++; n_bad++;
                $display("FAIL a_err_missing: err low at cycle %0d, want pulse at %0d", cyc, ea_t[0]);
                mon_ta = ea_t.pop_front();
            end
            if (a_err) begin
                if (ea_t.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL a_err_unexpected: err high at cycle %0d, want low", cyc);
                end else begin
                    mon_ta = ea_t.pop_front();
                    check("a_err_cycle", cyc, mon_ta);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (qb_t.size() > 0 && qb_t[0] < cyc) begin
                n_vec++; n_bad++;
                $display("FAIL b_rd_missing: no Rvalid by cycle %0d, want Rout %0h", cyc, qb_d[0]);
                mon_tb = qb_t.pop_front(); mon_db = qb_d.pop_front();
            end
            if (b_rvalid) begin
                if (qb_t.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL b_rd_unexpected: got Rvalid with Rout %0h at cycle %0d, want none", b_rout, cyc);
                end else begin
                    mon_tb = qb_t.pop_front(); mon_db = qb_d.pop_front();
                    check("b_rd_data", b_rout, mon_db);
                    check("b_rd_cycle", cyc, mon_tb);
                end
            end
            if (eb_t.size() > 0 && eb_t[0] < cyc) begin
                n_vec++; n_bad++;
                $display("FAIL b_err_missing: err low at cycle %0d, want pulse at %0d", cyc, eb_t[0]);
                mon_tb = eb_t.pop_front();
            end
            if (b_err) begin
                if (eb_t.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL b_err_unexpected: err high at cycle %0d, want low", cyc);
                end else begin
                    mon_tb = eb_t.pop_front();
                    check("b_err_cycle", cyc, mon_tb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        measure_busy(0, la, lb);
        check("init_busy_len_a", la, D_A);
        check("init_busy_len_b", lb, D_B);

        // Whole address space after init: zeros everywhere, B flags its missing top words.
        for (int i = 0; i < 32; i++) do_rd(AW'(i), '0, '0, 0, (i >= D_B));
        idle(3);

        do_wr(5'd3, 6'b101010, 0, 0);
        do_wr(5'd5, 6'b010101, 0, 0);
        do_wr(5'd7, 6'b111000, 0, 0);
        do_rd(5'd3, 6'b101010, 6'b101010, 0, 0);
        do_rd(5'd5, 6'b010101, 6'b010101, 0, 0);
        do_rd(5'd7, 6'b111000, 6'b111000, 0, 0);
        idle(3);

        // Collision: A returns the old word, B the incoming one; both store the new word.
        do_wr(5'd4, 6'b000111, 0, 0);
        exp_rd(6'b000111, 6'b110000);
        step(1, 5'd4, 1, 5'd4, 6'b110000, 0);
        do_rd(5'd4, 6'b110000, 6'b110000, 0, 0);
        idle(2);

        // Range: 25 and 30 are legal in A, out of range in B (no alias onto word 1).
        do_wr(5'd25, 6'b111111, 0, 1);
        do_rd(5'd25, 6'b111111, '0, 0, 1);
        do_rd(5'd1, '0, '0, 0, 0);
        do_rd(5'd4, 6'b110000, 6'b110000, 0, 0);
        do_rd(5'd30, '0, '0, 0, 1);
        idle(3);

        // clr right behind a read: the read keeps its pre-clear data.
        do_wr(5'd3, 6'b011011, 0, 0);
        do_rd(5'd3, 6'b011011, 6'b011011, 0, 0);
        step(0, '0, 0, '0, '0, 1);
        measure_busy(1, la, lb);
        check("clr_busy_len_a", la, D_A);
        check("clr_busy_len_b", lb, D_B);
        do_rd(5'd3, '0, '0, 0, 0);
        do_rd(5'd0, '0, '0, 0, 0);
        do_rd(5'd25, '0, '0, 0, 1);
        idle(3);

        // rst between edges while a read result (A) and an err pulse (B) are live.
        do_wr(5'd2, 6'b100001, 0, 0);
        idle(2);
        step(1, 5'd2, 1, 5'd30, 6'h15, 0);
        check("pre_rst_rvalid_a", a_rvalid, 1);
        check("pre_rst_err_b", b_err, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_read");
        @(posedge clk);
        #1;
        rst = 1'b0;
        measure_busy(0, la, lb);
        check("rst_read_busy_len_a", la, D_A);
        check("rst_read_busy_len_b", lb, D_B);

        // rst in the middle of the fill restarts it from pointer 0.
        do_wr(5'd2, 6'b100001, 0, 0);
        step(0, '0, 0, '0, '0, 1);
        idle(10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_init_busy_a", a_busy, 1);
        check("rst_mid_init_busy_b", b_busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        measure_busy(0, la, lb);
        check("rst_init_busy_len_a", la, D_A);
        check("rst_init_busy_len_b", lb, D_B);
        do_rd(5'd2, '0, '0, 0, 0);
        do_rd(5'd7, '0, '0, 0, 0);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
